// File: rtl/result_fetch_ctrl_pkg.sv
// Shared constants and types for the display-side result fetch controller.
package result_fetch_pkg;

    localparam int OP_SUMA  = 0;
    localparam int OP_RESTA = 1;
    localparam int OP_MULT  = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_POW   = 4;

    localparam int BASE_IDX_DEF = 2;
    localparam int NUM_OPS_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_UPD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/result_fetch_ctrl_if.sv
// Data-memory read port shared between the CPU and the result fetch controller.
interface result_fetch_ctrl_if #(
    parameter int AW = 6
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_grant;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    modport master (
        input  cpu_req, cpu_addr, mem_rdata,
        output cpu_grant, mem_rd_en, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, mem_rdata,
        input  cpu_grant, mem_rd_en, mem_addr
    );
endinterface

// File: rtl/result_fetch_ctrl_chk.sv
// Structural and protocol checks for result_fetch_ctrl, kept apart from the datapath.
module result_fetch_ctrl_chk #(
    parameter int AW       = 6,
    parameter int BASE_IDX = 2,
    parameter int NUM_OPS  = 5
) (
    input logic          clk,
    input logic          rst,
    input logic          cpu_req,
    input logic [AW-1:0] cpu_addr,
    input logic          cpu_grant,
    input logic          mem_rd_en,
    input logic [AW-1:0] mem_addr,
    input logic          sel_err,
    input logic [31:0]   result
);
    if (BASE_IDX + NUM_OPS - 1 >= 2**AW) begin : g_addr_overflow
        $error("result_fetch_ctrl: BASE_IDX+NUM_OPS-1 does not fit in AW bits");
    end

    a_grant_addr: assert property (@(posedge clk) disable iff (rst)
        cpu_grant |-> (mem_rd_en && (mem_addr == cpu_addr)));

    a_grant_req: assert property (@(posedge clk) disable iff (rst)
        cpu_grant |-> cpu_req);

    a_err_zero: assert property (@(posedge clk) disable iff (rst)
        sel_err |-> (result == 32'd0));
endmodule

// File: rtl/result_fetch_ctrl_sync_2ff.sv
// Two-stage synchronizer for a bus of quasi-static asynchronous inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_r;
    logic [W-1:0] q_r;

    // metastability filter chain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {W{1'b0}};
            q_r    <= {W{1'b0}};
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/result_fetch_ctrl.sv
// Fetches the selected arithmetic result word from data memory into a registered
// display value, sharing the read port with the CPU under bounded starvation.
module result_fetch_ctrl
    import result_fetch_pkg::*;
#(
    parameter int AW             = 6,
    parameter int BASE_IDX       = BASE_IDX_DEF,
    parameter int NUM_OPS        = NUM_OPS_DEF,
    parameter int REFRESH_CYCLES = 1000000,
    parameter int STARVE_MAX     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          sel_sw,
    result_fetch_ctrl_if.master bus,
    output logic [31:0]         result,
    output logic                result_valid,
    output logic                sel_err,
    output logic                busy
);
    localparam int RW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int STW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [RW-1:0]  REF_LAST    = RW'(REFRESH_CYCLES - 1);
    localparam logic [STW-1:0] STARVE_LAST = STW'(STARVE_MAX - 1);

    fetch_state_t   state_r;
    fetch_state_t   state_nxt_s;
    logic [2:0]     sel_s;
    logic [2:0]     last_sel_r;
    logic [RW-1:0]  ref_cnt_r;
    logic [STW-1:0] starve_r;
    logic           pend_r;
    logic           boot_r;
    logic [31:0]    data_r;
    logic [31:0]    result_r;
    logic           valid_r;
    logic           err_r;

    logic           sel_ok_s;
    logic           ref_hit_s;
    logic           trig_s;
    logic           pending_s;
    logic           own_s;
    logic [AW-1:0]  fetch_addr_s;

    sync_2ff #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sel_sw),
        .q   (sel_s)
    );

    // trigger sources and port ownership
    always_comb begin
        sel_ok_s     = (int'(sel_s) < NUM_OPS);
        ref_hit_s    = (ref_cnt_r == REF_LAST);
        trig_s       = (sel_s != last_sel_r) || ref_hit_s || boot_r;
        pending_s    = trig_s || pend_r;
        own_s        = (state_r == ST_REQ) && (!bus.cpu_req || (starve_r == STARVE_LAST));
        fetch_addr_s = AW'(BASE_IDX) + AW'(last_sel_r);
    end

    // read-port mux: the CPU keeps the port except on an owning REQ cycle
    always_comb begin
        bus.mem_rd_en = bus.cpu_req;
        bus.mem_addr  = bus.cpu_addr;
        bus.cpu_grant = bus.cpu_req;
        if (own_s) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = fetch_addr_s;
            bus.cpu_grant = 1'b0;
        end else begin
            bus.cpu_grant = bus.cpu_req;
        end
    end

    // fetch FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_s && sel_ok_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (own_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: state_nxt_s = ST_UPD;
            ST_UPD:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // state, trigger bookkeeping and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_sel_r <= 3'd0;
            ref_cnt_r  <= {RW{1'b0}};
            starve_r   <= {STW{1'b0}};
            pend_r     <= 1'b0;
            boot_r     <= 1'b1;
            data_r     <= 32'd0;
            result_r   <= 32'd0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ref_cnt_r <= ref_hit_s ? {RW{1'b0}} : (ref_cnt_r + RW'(1));
            case (state_r)
                ST_IDLE: begin
                    if (pending_s) begin
                        last_sel_r <= sel_s;
                        pend_r     <= 1'b0;
                        boot_r     <= 1'b0;
                        // unmapped codes resolve at once without touching memory
                        if (!sel_ok_s) begin
                            result_r <= 32'd0;
                            err_r    <= 1'b1;
                            valid_r  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (trig_s) begin
                        pend_r <= 1'b1;
                    end
                    if (!own_s) begin
                        starve_r <= starve_r + STW'(1);
                    end
                end
                ST_WAIT: begin
                    if (trig_s) begin
                        pend_r <= 1'b1;
                    end
                    data_r <= bus.mem_rdata;
                end
                ST_UPD: begin
                    if (trig_s) begin
                        pend_r <= 1'b1;
                    end
                    result_r <= data_r;
                    valid_r  <= (sel_s == last_sel_r);
                    err_r    <= 1'b0;
                    starve_r <= {STW{1'b0}};
                end
                default: begin
                    pend_r <= pend_r;
                end
            endcase
        end
    end

    assign result       = result_r;
    assign result_valid = valid_r;
    assign sel_err      = err_r;
    assign busy         = (state_r != ST_IDLE);

    result_fetch_ctrl_chk #(
        .AW       (AW),
        .BASE_IDX (BASE_IDX),
        .NUM_OPS  (NUM_OPS)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (bus.cpu_req),
        .cpu_addr  (bus.cpu_addr),
        .cpu_grant (bus.cpu_grant),
        .mem_rd_en (bus.mem_rd_en),
        .mem_addr  (bus.mem_addr),
        .sel_err   (err_r),
        .result    (result_r)
    );
endmodule

// File: tb/tb_result_fetch_ctrl.sv
// Self-checking bench for result_fetch_ctrl: directed scenarios plus randomized
// selector/CPU traffic compared against a memory-lookup reference model.
module tb_result_fetch_ctrl;
    import result_fetch_pkg::*;

    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sw  = 3'd0;
    logic [2:0]  sw2 = 3'd0;
    logic [31:0] result, result2;
    logic        result_valid, valid2, sel_err, err2, busy, busy2;

    logic [31:0] mem  [64];
    logic [31:0] mem2 [64];
    int          rd_cnt [64];
    int          rd_total = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    result_fetch_ctrl_if #(.AW(AW)) bus ();
    result_fetch_ctrl_if #(.AW(AW)) bus2 ();

    result_fetch_ctrl #(
        .AW(AW), .BASE_IDX(2), .NUM_OPS(5), .REFRESH_CYCLES(1000000), .STARVE_MAX(16)
    ) dut (
        .clk(clk), .rst(rst), .sel_sw(sw), .bus(bus),
        .result(result), .result_valid(result_valid), .sel_err(sel_err), .busy(busy)
    );

    result_fetch_ctrl #(
        .AW(AW), .BASE_IDX(2), .NUM_OPS(5), .REFRESH_CYCLES(8), .STARVE_MAX(16)
    ) dut_ref (
        .clk(clk), .rst(rst), .sel_sw(sw2), .bus(bus2),
        .result(result2), .result_valid(valid2), .sel_err(err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // behavioural memories with one-cycle read latency, plus fetch-read tally
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus2.mem_rd_en) bus2.mem_rdata <= mem2[bus2.mem_addr];
        if (!rst && bus.mem_rd_en && !bus.cpu_grant) begin
            rd_cnt[bus.mem_addr] = rd_cnt[bus.mem_addr] + 1;
            rd_total = rd_total + 1;
        end
    end

    function automatic logic [31:0] model_result(input logic [2:0] s);
        return (s < 3'd5) ? mem[2 + int'(s)] : 32'd0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int base2, base_t;
        bit found;
        rst = 1'b1;
        tick(4);
        n_tests++;
        if (result !== 32'd0 || result_valid !== 1'b0 || sel_err !== 1'b0 || busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: result=%h valid=%b err=%b busy=%b rd_en=%b, want all zero",
                     result, result_valid, sel_err, busy, bus.mem_rd_en);
        end
        base2  = rd_cnt[2];
        base_t = rd_total;
        rst    = 1'b0;
        found  = 1'b0;
        for (int i = 1; i <= 7 && !found; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1 && result === 32'h7) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL boot_fetch: result=%h valid=%b, want 00000007/1 within 7 cycles", result, result_valid);
        end
        tick(2);
        n_tests++;
        if (rd_cnt[2] - base2 != 1 || rd_total - base_t != 1) begin
            n_fail++;
            $display("FAIL boot_reads: addr2=%0d total=%0d, want 1/1", rd_cnt[2] - base2, rd_total - base_t);
        end
    endtask

    task automatic test_sel_change();
        int base5, base_t;
        mem[5] = 32'hFFFF_FFFE;
        base5  = rd_cnt[5];
        base_t = rd_total;
        sw     = 3'b011;
        tick(5);
        n_tests++;
        if (result !== 32'h7) begin
            n_fail++;
            $display("FAIL sel_latency_early: result=%h at cycle 5, want 00000007", result);
        end
        tick(1);
        n_tests++;
        if (result !== 32'hFFFF_FFFE || result_valid !== 1'b1 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_latency: result=%h valid=%b err=%b at cycle 6, want fffffffe/1/0",
                     result, result_valid, sel_err);
        end
        tick(4);
        n_tests++;
        if (rd_cnt[5] - base5 != 1 || rd_total - base_t != 1) begin
            n_fail++;
            $display("FAIL sel_reads: addr5=%0d total=%0d, want 1/1", rd_cnt[5] - base5, rd_total - base_t);
        end
    endtask

    task automatic test_invalid();
        int base_t, base6;
        base_t = rd_total;
        sw     = 3'b101;
        tick(8);
        n_tests++;
        if (rd_total != base_t || result !== 32'd0 || sel_err !== 1'b1 || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_sel: reads=%0d result=%h err=%b valid=%b, want 0/0/1/1",
                     rd_total - base_t, result, sel_err, result_valid);
        end
        mem[6] = 32'h0000_0400;
        base6  = rd_cnt[6];
        sw     = 3'b100;
        tick(8);
        n_tests++;
        if (result !== 32'h400 || sel_err !== 1'b0 || result_valid !== 1'b1 || rd_cnt[6] - base6 != 1) begin
            n_fail++;
            $display("FAIL recover_sel: result=%h err=%b valid=%b reads6=%0d, want 400/0/1/1",
                     result, sel_err, result_valid, rd_cnt[6] - base6);
        end
    endtask

    task automatic test_starvation();
        int first_busy, forced_at, blocked;
        logic [AW-1:0] forced_addr;
        first_busy   = -1;
        forced_at    = -1;
        blocked      = 0;
        forced_addr  = '0;
        mem[3]       = 32'hA000_0000 | 32'($urandom_range(0, 65535));
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 6'd40;
        sw           = 3'b001;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy && first_busy < 0) first_busy = i;
            if (!bus.cpu_grant) begin
                blocked++;
                forced_at   = i;
                forced_addr = bus.mem_addr;
            end
        end
        bus.cpu_req = 1'b0;
        n_tests++;
        if (blocked != 1) begin
            n_fail++;
            $display("FAIL starve_blocked: cpu denied %0d cycles, want 1", blocked);
        end
        n_tests++;
        if (forced_at - first_busy != 15 || forced_addr !== 6'd3) begin
            n_fail++;
            $display("FAIL starve_force: forced on REQ cycle %0d addr %0d, want 16 addr 3",
                     forced_at - first_busy + 1, forced_addr);
        end
        tick(2);
        n_tests++;
        if (result !== mem[3] || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_result: result=%h valid=%b, want %h/1", result, result_valid, mem[3]);
        end
    endtask

    task automatic test_mid_change();
        int base3, base4;
        bit seen;
        mem[4] = 32'd9;
        mem[3] = 32'd3;
        base3  = rd_cnt[3];
        base4  = rd_cnt[4];
        sw     = 3'b010;
        seen   = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        sw = 3'b001;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b, want 1 within 10 cycles", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (result === 32'd9) begin
                seen = 1'b1;
                n_tests++;
                if (result_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_stale_valid: valid=%b with stale result 9, want 0", result_valid);
                end
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_stale: result=%h, want 00000009 within 10 cycles", result);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (result === 32'd3 && result_valid === 1'b1) seen = 1'b1;
        end
        tick(6);
        n_tests++;
        if (!seen || rd_cnt[3] - base3 != 1 || rd_cnt[4] - base4 != 1) begin
            n_fail++;
            $display("FAIL mid_final: result=%h valid=%b reads3=%0d reads4=%0d, want 3/1/1/1",
                     result, result_valid, rd_cnt[3] - base3, rd_cnt[4] - base4);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_res;
        for (int k = 2; k <= 6; k++) mem[k] = $urandom;
        for (int it = 0; it < 16; it++) begin
            sw = 3'($urandom_range(0, 7));
            for (int c = 0; c < int'($urandom_range(4, 40)); c++) begin
                @(negedge clk);
                if (bus.cpu_grant === 1'b1) begin
                    n_tests++;
                    if (bus.mem_addr !== bus.cpu_addr || bus.mem_rd_en !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rnd_cpu_port: addr=%0d rd_en=%b, want %0d/1",
                                 bus.mem_addr, bus.mem_rd_en, bus.cpu_addr);
                    end
                end else if (bus.mem_rd_en === 1'b1) begin
                    n_tests++;
                    if (bus.mem_addr < 6'd2 || bus.mem_addr > 6'd6) begin
                        n_fail++;
                        $display("FAIL rnd_fetch_addr: addr=%0d, want 2..6", bus.mem_addr);
                    end
                end
                // a denied CPU must hold its request unchanged
                if (!(bus.cpu_req && !bus.cpu_grant)) begin
                    bus.cpu_req  = 1'($urandom_range(0, 1));
                    bus.cpu_addr = 6'($urandom_range(0, 63));
                end
                if ($urandom_range(0, 7) == 0) sw = 3'($urandom_range(0, 7));
            end
            bus.cpu_req = 1'b0;
            tick(16);
            exp_res = model_result(sw);
            n_tests++;
            if (result !== exp_res || result_valid !== 1'b1 || sel_err !== (sw >= 3'd5)) begin
                n_fail++;
                $display("FAIL rnd_settle: sel=%0d result=%h valid=%b err=%b, want %h/1/%b",
                         sw, result, result_valid, sel_err, exp_res, (sw >= 3'd5));
            end
        end
    endtask

    task automatic test_refresh();
        bit seen, prev;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (result2 === 32'd5 && valid2 === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL refresh_initial: result=%h valid=%b, want 00000005/1", result2, valid2);
        end
        mem2[2] = 32'd6;
        seen    = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (result2 === 32'd6 && valid2 === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL refresh_update: result=%h, want 00000006 within 16 cycles", result2);
        end
        seen = 1'b0;
        prev = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (busy2 && !prev) seen = 1'b1;
            prev = busy2;
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (!seen || result2 !== 32'd0 || valid2 !== 1'b0 || err2 !== 1'b0 || busy2 !== 1'b0 || bus2.mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_req: req_seen=%b result=%h valid=%b err=%b busy=%b rd_en=%b, want 1/0/0/0/0/0",
                     seen, result2, valid2, err2, busy2, bus2.mem_rd_en);
        end
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (result2 === 32'd6 && valid2 === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_recover: result=%h valid=%b, want 00000006/1", result2, valid2);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = $urandom;
            mem2[i] = 32'd0;
        end
        mem[2]        = 32'h0000_0007;
        mem2[2]       = 32'd5;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus2.cpu_req  = 1'b0;
        bus2.cpu_addr = '0;

        test_reset();
        test_sel_change();
        test_invalid();
        test_starvation();
        test_mid_change();
        test_random();
        test_refresh();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/result_fetch_ctrl.md
Name: result_fetch_ctrl

Overview:
- Sequences display-side reads of the arithmetic result words (RAM[2]..RAM[6]: SUMA, RESTA, MULT, DIV, POW) out of data memory.
- Shares the single data-memory read port with the CPU; the CPU has priority, with bounded-starvation protection for the fetch side.
- The registered 32-bit result it produces drives the 7-seg/LED display path. It replaces a purely combinational select with a registered, refreshed value.

Parameters:
- AW, 6: word-address width of the data-memory port.
- BASE_IDX, 2: word index of RAM[2] (SUMA); the target word is BASE_IDX + sel.
- NUM_OPS, 5: number of valid selector codes (0..4).
- REFRESH_CYCLES, 1000000: periodic re-fetch interval in clk cycles (20 ms at 50 MHz).
- STARVE_MAX, 16: consecutive cycles a pending fetch may be blocked by the CPU before it is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sel_sw  in  3  raw switches SW[2:0]; asynchronous to clk
- cpu_req  in  1  CPU wants the read port this cycle
- cpu_addr  in  AW  CPU word address
- cpu_grant  out  1  CPU owns the port this cycle (combinational)
- mem_rd_en  out  1  read strobe to data memory
- mem_addr  out  AW  word address to data memory
- mem_rdata  in  32  read data; valid exactly 1 cycle after mem_rd_en
- result  out  32  registered selected result
- result_valid  out  1  result holds data for the current selector
- sel_err  out  1  selector code >= NUM_OPS
- busy  out  1  fetch FSM not in IDLE

Behaviour:
- Sync: sel_sw passes a 2-FF synchronizer to give sel_s. last_sel holds the code of the last fetch.
- Trigger: a fetch becomes pending when any of these occurs: sel_s != last_sel; the refresh counter reaches REFRESH_CYCLES-1 (it then wraps to 0); or the first cycle after rst.
  - A trigger arriving while busy sets pend. pend is consumed on return to IDLE, so exactly one extra fetch runs, never more.
- FSM states: IDLE, REQ, WAIT, UPD.
  - IDLE -> REQ on pending with sel_s < NUM_OPS. last_sel <= sel_s on this transition.
  - Invalid code (sel_s >= NUM_OPS): no memory access; result <= 0, sel_err <= 1, result_valid <= 1, last_sel <= sel_s; stay in IDLE.
  - REQ: the fetch owns the port when cpu_req=0 or starve_cnt==STARVE_MAX-1.
    - Owning: mem_rd_en=1, mem_addr=BASE_IDX+last_sel, cpu_grant=0, go to WAIT.
    - Blocked: starve_cnt increments.
  - WAIT: capture mem_rdata, go to UPD.
  - UPD: result <= captured data, result_valid <= 1, sel_err <= 0, starve_cnt <= 0, go to IDLE.
- Port arbitration: outside an owning REQ cycle, mem_addr=cpu_addr, mem_rd_en=cpu_req, cpu_grant=cpu_req.
  - A CPU that is blocked sees cpu_grant=0 and must hold its request.
- Latency, uncontended: from the edge where sel_s changes, result updates 4 cycles later: IDLE, REQ, WAIT, UPD, register.
- Selector change mid-fetch: the in-flight fetch completes and result_valid is cleared in UPD. The new code is re-fetched; result_valid rises only once result matches sel_s.
- Reset mid-operation: state aborts to IDLE immediately. Any outstanding mem_rdata is ignored.
- Reset values: result=0, result_valid=0, sel_err=0, busy=0, mem_rd_en=0, refresh counter=0, starve_cnt=0, pend=0, last_sel=0, and the post-reset trigger flag=1.
- Width: the address sum is computed in AW bits; BASE_IDX+NUM_OPS-1 < 2**AW is checked by an elaboration assertion.

Decomposition:
- Package result_fetch_pkg holds:
  - op-code constants OP_SUMA=0, OP_RESTA=1, OP_MULT=2, OP_DIV=3, OP_POW=4
  - BASE_IDX default
  - FSM state enum fetch_state_t
- One natural sub-module, sync_2ff: a parameterizable-width 2-stage synchronizer used for sel_sw.

Test Plan:
- Reset then SW=000, RAM[2]=0x0000_0007, cpu_req=0 -> one read at addr 2; result=0x7 and result_valid=1 within 7 cycles of rst deassert.
- SW 000->011 with RAM[5]=0xFFFF_FFFE -> exactly one read at addr 5; result=0xFFFF_FFFE 6 cycles after the switch change (2 sync + 4); sel_err=0.
- SW=101 -> no mem_rd_en; result=0, sel_err=1, result_valid=1. SW then 100 with RAM[6]=0x400 -> result=0x400, sel_err=0.
- cpu_req held high 40 cycles during a pending fetch -> fetch read forced on cycle STARVE_MAX (cpu_grant=0 for exactly that one cycle); the CPU is served otherwise.
- SW change during WAIT, 010->001, with RAM[4]=9 and RAM[3]=3 -> result briefly 9 with result_valid=0, then one more read at addr 3; final result=3 with result_valid=1.
- REFRESH_CYCLES=8 with RAM[2] changed 5->6 while SW=000 -> result becomes 6 after the next refresh wrap. Assert rst in REQ -> all outputs take reset values the next cycle.
